// File: rtl/lenet_uart_pkg.sv
// Shared UART protocol constants for the LeNet-5 host link (receive router and response transmitter).
package lenet_uart_pkg;

   localparam int unsigned CLKS_PER_BIT = 868;
   localparam int unsigned NUM_CLASSES  = 10;

   localparam logic [7:0] CMD_DIGIT  = 8'hCC;
   localparam logic [7:0] CMD_SCORES = 8'hCD;
   localparam logic [7:0] CMD_DBG0   = 8'hD0;
   localparam logic [7:0] CMD_DBG1   = 8'hD1;
   localparam logic [7:0] CMD_DBG2   = 8'hD2;
   localparam logic [7:0] RESP_ERR   = 8'hEE;

   localparam logic [7:0] FRAME_HDR0 = 8'hAA;
   localparam logic [7:0] FRAME_HDR1 = 8'h55;
   localparam logic [7:0] FRAME_TRL0 = 8'hBB;
   localparam logic [7:0] FRAME_TRL1 = 8'h66;

   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_HDR, ST_PAY, ST_CSUM} resp_state_e;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_phase_e;

   function automatic logic is_resp_cmd(input logic [7:0] c);
      return (c == CMD_DIGIT) || (c == CMD_SCORES) || (c == CMD_DBG0) ||
             (c == CMD_DBG1) || (c == CMD_DBG2);
   endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 byte serialiser, transmit-side mirror of uart_rx.
module uart_tx
   import lenet_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   tx_phase_e       phase_q, phase_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      sh_q, sh_d;
   logic            tx_q, tx_d;
   logic            bit_end;

   assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= TX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
      end
   end

   // A start request is also taken in the last stop-bit cycle so bytes chain with no idle gap.
   always_comb begin
      phase_d = phase_q;
      cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      case (phase_q)
         TX_IDLE: begin
            cnt_d = '0;
            if (tx_start) begin
               phase_d = TX_START;
               sh_d    = tx_data;
            end
         end
         TX_START: if (bit_end) begin
            phase_d = TX_DATA;
            bit_d   = '0;
         end
         TX_DATA: if (bit_end) begin
            sh_d = sh_q >> 1;
            if (bit_q == 3'd7) phase_d = TX_STOP;
            else               bit_d   = bit_q + 1'b1;
         end
         default: if (bit_end) begin
            if (tx_start) begin
               phase_d = TX_START;
               sh_d    = tx_data;
            end else begin
               phase_d = TX_IDLE;
            end
         end
      endcase
      case (phase_d)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = sh_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   // Done leads the end of the stop bit by one cycle, leaving the caller time to queue the next byte.
   assign tx_done = (phase_q == TX_STOP) && (cnt_q == CW'(CLKS_PER_BIT - 2));
   assign tx_busy = (phase_q != TX_IDLE);
   assign tx      = tx_q;

endmodule

// File: rtl/uart_response_tx.sv
// Response framer: snapshots the requested result and sends [cmd][payload][xor checksum] over 8N1.
module uart_response_tx
   import lenet_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = lenet_uart_pkg::CLKS_PER_BIT,
   parameter int unsigned NUM_CLASSES  = lenet_uart_pkg::NUM_CLASSES,
   parameter int unsigned SCORE_W      = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [7:0]                     cmd_data,
   input  logic                           cmd_valid,
   input  logic                           result_valid,
   input  logic [3:0]                     pred_digit,
   input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
   input  logic [31:0]                    debug0,
   input  logic [31:0]                    debug1,
   input  logic [31:0]                    debug2,
   output logic                           tx,
   output logic                           busy,
   output logic                           cmd_dropped
);

   localparam int unsigned PW = NUM_CLASSES * SCORE_W;
   localparam int unsigned NB = PW / 8;
   localparam int unsigned LW = $clog2(NB + 1);

   resp_state_e   state_q, state_d;
   logic [7:0]    cmd_q, cmd_d, pend_cmd_q, pend_cmd_d, csum_q, csum_d;
   logic          pend_v_q, pend_v_d, issued_q, issued_d, drop_q, drop_d;
   logic [PW-1:0] snap_q, snap_d;
   logic [LW-1:0] len_q, len_d, cnt_q, cnt_d;
   logic          tx_start, tx_done, tx_busy, cmd_ok, accept, store, drain, last_byte;
   logic [7:0]    tx_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cmd_q      <= '0;
         pend_cmd_q <= '0;
         pend_v_q   <= 1'b0;
         csum_q     <= '0;
         issued_q   <= 1'b0;
         drop_q     <= 1'b0;
         snap_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         pend_cmd_q <= pend_cmd_d;
         pend_v_q   <= pend_v_d;
         csum_q     <= csum_d;
         issued_q   <= issued_d;
         drop_q     <= drop_d;
         snap_q     <= snap_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
      end
   end

   assign last_byte = (cnt_q == len_q - 1'b1);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_HDR;
         ST_HDR:  if (tx_done) state_d = ST_PAY;
         ST_PAY:  if (tx_done && last_byte) state_d = ST_CSUM;
         ST_CSUM: if (tx_done) state_d = pend_v_q ? ST_LOAD : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // The header is issued from LOAD itself so a pending frame follows the previous checksum without a gap.
   always_comb begin
      tx_start = 1'b0;
      tx_data  = '0;
      case (state_q)
         ST_LOAD: begin
            tx_start = 1'b1;
            tx_data  = cmd_q;
         end
         ST_PAY: begin
            tx_start = !issued_q;
            tx_data  = snap_q[{cnt_q, 3'b000} +: 8];
         end
         ST_CSUM: begin
            tx_start = !issued_q;
            tx_data  = csum_q;
         end
         default: ;
      endcase
      busy        = (state_q != ST_IDLE) || tx_busy;
      cmd_dropped = drop_q;
   end

   always_comb begin
      cmd_ok     = cmd_valid && is_resp_cmd(cmd_data);
      accept     = cmd_ok && (state_q == ST_IDLE);
      drain      = (state_q == ST_CSUM) && tx_done && pend_v_q;
      store      = cmd_ok && (state_q != ST_IDLE) && (!pend_v_q || drain);
      drop_d     = cmd_ok && (state_q != ST_IDLE) && pend_v_q && !drain;
      pend_v_d   = store ? 1'b1 : (drain ? 1'b0 : pend_v_q);
      pend_cmd_d = store ? cmd_data : pend_cmd_q;
      cmd_d      = accept ? cmd_data : (drain ? pend_cmd_q : cmd_q);

      snap_d   = snap_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      csum_d   = csum_q;
      issued_d = tx_start ? 1'b1 : (tx_done ? 1'b0 : issued_q);
      if (state_q == ST_LOAD) begin
         cnt_d  = '0;
         csum_d = cmd_q;
         len_d  = LW'(4);
         snap_d = PW'(RESP_ERR);
         case (cmd_q)
            CMD_DIGIT: begin
               len_d = LW'(1);
               if (result_valid) snap_d = PW'({4'h0, pred_digit});
            end
            CMD_SCORES: begin
               len_d = result_valid ? LW'(NB) : LW'(1);
               if (result_valid) snap_d = scores;
            end
            CMD_DBG0: snap_d = PW'(debug0);
            CMD_DBG1: snap_d = PW'(debug1);
            default:  snap_d = PW'(debug2);
         endcase
      end else if (state_q == ST_PAY) begin
         if (tx_start) csum_d = csum_q ^ tx_data;
         if (tx_done && !last_byte) cnt_d = cnt_q + 1'b1;
      end
   end

   uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_tx (
      .clk      (clk),
      .rst      (rst),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx       (tx),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

endmodule

// File: tb/tb_uart_response_tx.sv
// Directed bench for uart_response_tx: decodes the serial line and compares frames to hand-computed bytes.
module tb_uart_response_tx;

   localparam int unsigned C  = 16;
   localparam int unsigned NC = 10;
   localparam int unsigned SW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [7:0]      cmd_data;
   logic            cmd_valid;
   logic            result_valid;
   logic [3:0]      pred_digit;
   logic [NC*SW-1:0] scores;
   logic [31:0]     debug0, debug1, debug2;
   logic            tx, busy, cmd_dropped;

   uart_response_tx #(
      .CLKS_PER_BIT (C),
      .NUM_CLASSES  (NC),
      .SCORE_W      (SW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_data     (cmd_data),
      .cmd_valid    (cmd_valid),
      .result_valid (result_valid),
      .pred_digit   (pred_digit),
      .scores       (scores),
      .debug0       (debug0),
      .debug1       (debug1),
      .debug2       (debug2),
      .tx           (tx),
      .busy         (busy),
      .cmd_dropped  (cmd_dropped)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_run = 0, n_fail = 0;
   int drops = 0, busy_cyc = 0, ferr = 0, acc = 0;
   bit tx_low = 1'b0;
   logic [7:0] rx_q[$];
   int         rx_t[$];
   logic [7:0] exp_q[$];

   always @(negedge clk) begin
      if (cmd_dropped === 1'b1) drops++;
      if (busy === 1'b1) busy_cyc++;
      if (!rst && tx === 1'b0) tx_low = 1'b1;
   end

   // Line decoder: samples each bit near its centre, discards a byte cut short by reset.
   always begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
         logic [9:0] sh;
         bit ab;
         int t0;
         t0 = cyc;
         ab = 1'b0;
         sh = '0;
         for (int k = 1; k <= int'(C / 2 + 9 * C); k++) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
            if (k >= int'(C / 2) && (k - int'(C / 2)) % int'(C) == 0) sh[(k - int'(C / 2)) / int'(C)] = tx;
         end
         if (!ab) begin
            if (sh[0] !== 1'b0 || sh[9] !== 1'b1) ferr++;
            rx_q.push_back(sh[8:1]);
            rx_t.push_back(t0);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_rx();
      rx_q.delete();
      rx_t.delete();
      exp_q.delete();
      ferr = 0;
   endtask

   task automatic send_cmd(input logic [7:0] b);
      @(negedge clk);
      cmd_data  = b;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      acc       = cyc;
   endtask

   task automatic wait_idle(input int budget);
      int i;
      for (i = 0; i < budget && busy !== 1'b0; i++) @(negedge clk);
      check("wait_idle_timeout", (i < budget) ? 32'd0 : 32'd1, 32'd0);
   endtask

   task automatic expect_frame(input string tag, input int budget);
      int bad;
      for (int i = 0; i < budget && rx_q.size() < exp_q.size(); i++) @(negedge clk);
      check({tag, "_len"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s_b%0d", tag, i), (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD_BEEF,
               {24'h0, exp_q[i]});
      bad = 0;
      for (int i = 1; i < rx_t.size(); i++)
         if (rx_t[i] - rx_t[i-1] != int'(10 * C)) bad++;
      check({tag, "_gap"}, bad, 0);
      check({tag, "_framing"}, ferr, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; result_valid = 1'b0; pred_digit = '0;
      scores = '0; debug0 = '0; debug1 = '0; debug2 = '0;
      repeat (5) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_drop", cmd_dropped, 0);
      rst = 1'b0;
      tx_low = 1'b0;
      repeat (1000) @(negedge clk);
      check("idle_tx_low", tx_low, 0);
      check("idle_busy", busy, 0);
      check("idle_bytes", rx_q.size(), 0);

      // unknown command code: silently ignored
      send_cmd(8'h55);
      check("ign_busy", busy, 0);
      repeat (300) @(negedge clk);
      check("ign_bytes", rx_q.size(), 0);
      check("ign_drop", drops, 0);

      result_valid = 1'b1; pred_digit = 4'd7;
      clear_rx(); busy_cyc = 0;
      send_cmd(8'hCC);
      check("cc_busy_rise", busy, 1);
      exp_q = '{8'hCC, 8'h07, 8'hCB};
      expect_frame("cc", 2000);
      wait_idle(200);
      check("cc_latency", (rx_t.size() > 0) ? ((rx_t[0] - acc) >= 1 && (rx_t[0] - acc) <= 3) : 1'b0, 1);
      check("cc_busy_len", (busy_cyc >= int'(30 * C) - 3) && (busy_cyc <= int'(30 * C) + 3), 1);

      debug0 = 32'h1234_5678;
      clear_rx();
      send_cmd(8'hD0);
      exp_q = '{8'hD0, 8'h78, 8'h56, 8'h34, 8'h12, 8'hD8};
      expect_frame("d0", 2000);
      wait_idle(200);

      scores = '0; scores[31:0] = 32'h0000_0100;
      clear_rx();
      send_cmd(8'hCD);
      exp_q = '{8'hCD, 8'h00, 8'h01, 8'h00, 8'h00};
      for (int i = 0; i < 36; i++) exp_q.push_back(8'h00);
      exp_q.push_back(8'hCC);
      for (int i = 0; i < 5000 && rx_q.size() < 10; i++) @(negedge clk);
      scores = '1; result_valid = 1'b0;
      expect_frame("cd", 10000);
      wait_idle(200);
      scores = '0;

      result_valid = 1'b0;
      clear_rx();
      send_cmd(8'hCC);
      exp_q = '{8'hCC, 8'hEE, 8'h22};
      expect_frame("err", 2000);
      wait_idle(200);
      result_valid = 1'b1;

      // D1 frame, D2 held pending, CC discarded
      debug1 = 32'hA1B2_C3D4; debug2 = 32'h0F1E_2D3C;
      clear_rx(); drops = 0;
      send_cmd(8'hD1);
      repeat (50) @(negedge clk);
      send_cmd(8'hD2);
      repeat (20) @(negedge clk);
      send_cmd(8'hCC);
      exp_q = '{8'hD1, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'hD5, 8'hD2, 8'h3C, 8'h2D, 8'h1E, 8'h0F, 8'hD2};
      expect_frame("b2b", 5000);
      wait_idle(200);
      repeat (400) @(negedge clk);
      check("b2b_drops", drops, 1);
      check("b2b_tail", rx_q.size(), 12);

      clear_rx();
      send_cmd(8'hD0);
      repeat (40) @(negedge clk);
      send_cmd(8'hD1);
      for (int i = 0; i < 2000 && rx_q.size() < 2; i++) @(negedge clk);
      repeat (40) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_tx", tx, 1);
      check("mid_rst_busy", busy, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n = rx_q.size();
      tx_low = 1'b0;
      repeat (800) @(negedge clk);
      check("mid_rst_no_pending", rx_q.size(), n);
      check("mid_rst_line_idle", tx_low, 0);
      check("mid_rst_busy_after", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_response_tx.md
Name: uart_response_tx

Overview:
Return-path UART framer/transmitter for the LeNet-5 inference core. It accepts command bytes forwarded by the receive-side router: 0xCC (digit), 0xCD (scores), and 0xD0/0xD1/0xD2 (debug). For each accepted command it snapshots the requested result and serialises a framed response to the host over 8N1 UART. It is the counterpart of the receive router and shares that router's baud rate and protocol constants.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200).
NUM_CLASSES, 10, number of score words in a 0xCD response.
SCORE_W, 32, width of each signed score word; must be a multiple of 8.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cmd_data  in  8  command byte from the router
cmd_valid  in  1  one-cycle strobe qualifying cmd_data
result_valid  in  1  high when pred_digit and scores hold a completed inference
pred_digit  in  4  predicted class, 0..9
scores  in  NUM_CLASSES*SCORE_W  score words; class 0 in bits [SCORE_W-1:0]
debug0, debug1, debug2  in  32 each  debug words returned for 0xD0, 0xD1 and 0xD2
tx  out  1  UART serial line, idle high
busy  out  1  high from command accept until the checksum stop bit ends
cmd_dropped  out  1  one-cycle pulse when a command is discarded

Behaviour:
- Reset (asynchronous, active-high): tx=1, busy=0, cmd_dropped=0, FSM=IDLE, pending slot empty, byte counter 0, checksum 0. Asserting reset mid-frame aborts the frame immediately and the line returns high.
- Frame format: [echo of command byte][payload][checksum]. The checksum is the XOR of every preceding byte in the frame, header included. Bytes are sent back to back with no idle gap between the stop bit of one byte and the start bit of the next.
- Payload, 0xCC: one byte, {4'h0, pred_digit}.
- Payload, 0xCD: NUM_CLASSES*SCORE_W/8 bytes (40 at defaults). Order is class 0 first; each word is little-endian.
- Payload, 0xD0/0xD1/0xD2: 4 bytes of debug0/1/2, little-endian.
- Error payload: if 0xCC or 0xCD is accepted while result_valid=0, the payload is the single byte 0xEE.
- Other command codes: ignored with no response and no cmd_dropped pulse.
- Snapshot: the selected payload source (and result_valid) is captured into an internal register on the accept cycle. Input changes during the frame do not affect it.
- FSM states: IDLE -> LOAD (snapshot, checksum=0) -> HDR -> PAY (count 0..N-1) -> CSUM -> IDLE, or -> LOAD if the pending slot is full.
  - Each send state issues tx_start to the sub-module and waits for its done pulse before advancing.
  - The checksum accumulates as each byte is issued.
- Latency: with cmd_valid high at cycle N in IDLE, busy=1 at N+1 and tx falls (header start bit) no later than N+3.
- Frame duration: (payload+2)*10*CLKS_PER_BIT cycles from the header start bit to the end of the checksum stop bit.
- busy: falls on the cycle after the checksum stop bit completes, unless a pending command starts, in which case busy stays high.
- Pending slot (one entry): a valid command arriving while busy with the slot empty is stored, and is snapshotted when its frame starts.
  - A command arriving while the slot is full is discarded and cmd_dropped pulses.
  - A command arriving on the same cycle the slot drains is stored, not dropped.
- UART bit timing: start bit 0, 8 data bits LSB first, stop bit 1, each bit held exactly CLKS_PER_BIT cycles.

Decomposition:
- Package lenet_uart_pkg holds:
  - command codes CMD_DIGIT=8'hCC, CMD_SCORES=8'hCD, CMD_DBG0..2=8'hD0..D2, RESP_ERR=8'hEE;
  - frame markers AA/55 and BB/66;
  - CLKS_PER_BIT, NUM_CLASSES and the FSM state enum.
- Sub-module uart_tx (byte serialiser: tx_start/tx_data in; tx, tx_busy, tx_done out), which mirrors the existing uart_rx.

Test Plan:
- Reset held, then released: tx=1, busy=0, and tx stays 1 for 1000 cycles with no cmd_valid.
- result_valid=1, pred_digit=7, cmd 0xCC: line decodes CC 07 CB; busy high for 3*10*CLKS_PER_BIT cycles (±3).
- debug0=0x12345678, cmd 0xD0: line decodes D0 78 56 34 12 D8.
- score0=0x00000100, others 0, cmd 0xCD: 42 bytes decoded, CD 00 01 00 00, then 36×00, then CC. Change scores mid-frame and confirm the output is unchanged.
- result_valid=0, cmd 0xCC: line decodes CC EE 22.
- Back-to-back commands:
  - 0xD1 then 0xD2 then 0xCC during the first frame: D1 frame, then D2 frame with no gap, and cmd_dropped pulses exactly once, for 0xCC.
  - Reset asserted mid-payload: tx=1 immediately, busy=0, and the pending command is discarded.
